// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the 5-stage pipeline.
// Holds the datapath width, the fetch FSM state encoding, the NOP bubble
// instruction, the default reset PC and the opcode constants used by the
// fetch and decode stages.
package pipeline_pkg;

  localparam int WORD_W = 16;

  // Default PC loaded on reset; if_stage can override it by parameter.
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  // BR with nzp=000: never taken, so it acts as the pipeline bubble.
  localparam logic [WORD_W-1:0] NOP = 16'h0000;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDW = 4'b0110;
  localparam logic [3:0] OP_STW = 4'b0111;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_t;

endpackage : pipeline_pkg

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage.
// Owns the PC, fetches from a single-outstanding-request instruction memory
// and drives the IF/ID register (IR, PC_OUT) into decode. Inserts NOP bubbles
// when no instruction is available, squashes on a taken branch, and parks a
// returned instruction in a one-entry skid buffer while decode is stalled.
//
// Ports:
//   i_clk         clock, all state on the rising edge
//   i_rst_n       asynchronous active-low reset
//   i_stall       decode stall, IR/PC_OUT hold
//   i_branch      taken branch resolved in decode
//   i_pc_offset   sign-extended branch offset
//   i_imem_rdata  instruction data from memory
//   i_imem_valid  i_imem_rdata valid, one pulse per request
//   o_imem_req    single-cycle fetch request (combinational)
//   o_imem_addr   word address, valid while o_imem_req=1 (combinational)
//   o_ir          IF/ID instruction register
//   o_pc_out      PC of the instruction in o_ir
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_branch,
  input  logic [WORD_W-1:0] i_pc_offset,
  input  logic [WORD_W-1:0] i_imem_rdata,
  input  logic              i_imem_valid,
  output logic              o_imem_req,
  output logic [WORD_W-1:0] o_imem_addr,
  output logic [WORD_W-1:0] o_ir,
  output logic [WORD_W-1:0] o_pc_out
);

  fetch_state_t      r_state;
  logic              r_run;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_pc_out;
  logic [WORD_W-1:0] r_buf;

  fetch_state_t      w_state_nxt;
  logic [WORD_W-1:0] w_pc_nxt;
  logic [WORD_W-1:0] w_ir_nxt;
  logic [WORD_W-1:0] w_pc_out_nxt;
  logic [WORD_W-1:0] w_buf_nxt;
  logic              w_req;
  logic [WORD_W-1:0] w_addr;
  logic [WORD_W-1:0] w_target;
  logic [WORD_W-1:0] w_pc_inc;
  logic [WORD_W-1:0] w_ir_bubble;

  // PC_OUT still holds the branch's own PC because decode stalls on BRANCH.
  assign w_target    = r_pc_out + 16'd1 + i_pc_offset;
  assign w_pc_inc    = r_pc + 16'd1;
  // With nothing to deliver, IR keeps its value under stall, else takes a bubble.
  assign w_ir_bubble = i_stall ? r_ir : NOP;

  // State, PC and IF/ID registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_REQ;
      r_run    <= 1'b0;
      r_pc     <= RESET_PC;
      r_ir     <= NOP;
      r_pc_out <= 16'h0000;
      r_buf    <= NOP;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        r_state  <= w_state_nxt;
        r_pc     <= w_pc_nxt;
        r_ir     <= w_ir_nxt;
        r_pc_out <= w_pc_out_nxt;
        r_buf    <= w_buf_nxt;
      end
    end
  end

  // Next-state, datapath update and memory request generation.
  // r_run keeps the request low until the first edge after reset release.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_pc_out_nxt = r_pc_out;
    w_buf_nxt    = r_buf;
    w_req        = 1'b0;
    w_addr       = r_pc;

    if (r_run) begin
      case (r_state)
        S_REQ: begin
          w_req = 1'b1;
          if (i_branch) begin
            // The request goes out anyway; its response is drained later.
            w_pc_nxt    = w_target;
            w_ir_nxt    = NOP;
            w_state_nxt = S_DRAIN;
          end else begin
            w_ir_nxt    = w_ir_bubble;
            w_state_nxt = S_WAIT;
          end
        end

        S_WAIT: begin
          if (i_imem_valid) begin
            if (i_branch) begin
              w_pc_nxt    = w_target;
              w_ir_nxt    = NOP;
              w_state_nxt = S_REQ;
            end else if (i_stall) begin
              w_buf_nxt   = i_imem_rdata;
              w_state_nxt = S_HOLD;
            end else begin
              // Deliver and issue the next fetch back-to-back.
              w_ir_nxt     = i_imem_rdata;
              w_pc_out_nxt = r_pc;
              w_pc_nxt     = w_pc_inc;
              w_req        = 1'b1;
              w_addr       = w_pc_inc;
              w_state_nxt  = S_WAIT;
            end
          end else begin
            if (i_branch) begin
              w_pc_nxt    = w_target;
              w_ir_nxt    = NOP;
              w_state_nxt = S_DRAIN;
            end else begin
              w_ir_nxt    = w_ir_bubble;
              w_state_nxt = S_WAIT;
            end
          end
        end

        S_DRAIN: begin
          // Latest branch wins; the squashed response is simply dropped.
          if (i_branch) begin
            w_pc_nxt = w_target;
            w_ir_nxt = NOP;
          end else begin
            w_ir_nxt = w_ir_bubble;
          end
          if (i_imem_valid) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end

        S_HOLD: begin
          if (i_branch) begin
            w_buf_nxt   = NOP;
            w_pc_nxt    = w_target;
            w_ir_nxt    = NOP;
            w_state_nxt = S_REQ;
          end else if (!i_stall) begin
            w_ir_nxt     = r_buf;
            w_pc_out_nxt = r_pc;
            w_pc_nxt     = w_pc_inc;
            w_buf_nxt    = NOP;
            w_state_nxt  = S_REQ;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end

        default: begin
          w_state_nxt = S_REQ;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign o_imem_req  = w_req;
  assign o_imem_addr = w_addr;
  assign o_ir        = r_ir;
  assign o_pc_out    = r_pc_out;

endmodule : if_stage

// File: tb/tb_if_stage.sv
// tb_if_stage: directed, table-driven bench for if_stage.
// The main instance has its memory interface driven cycle by cycle from a
// vector table with hand-computed expectations; a second instance with
// RESET_PC=16'hFFFF runs against a tiny 1-cycle memory to cover PC wrap.
module tb_if_stage;

  typedef struct {
    logic        stall;
    logic        branch;
    logic [15:0] offset;
    logic        valid;
    logic [15:0] rdata;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic [15:0] exp_ir;
    logic [15:0] exp_pc_out;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [15:0] offset;
  logic        valid;
  logic [15:0] rdata;
  logic        req;
  logic [15:0] addr;
  logic [15:0] ir;
  logic [15:0] pc_out;

  logic        w_rst_n;
  logic        w_valid;
  logic [15:0] w_rdata;
  logic        w_req;
  logic [15:0] w_addr;
  logic [15:0] w_ir;
  logic [15:0] w_pc_out;

  int checks;
  int failures;
  int cur;
  vec_t vecs[$];

  if_stage #(.RESET_PC(16'h0000)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_branch(branch),
    .i_pc_offset(offset), .i_imem_rdata(rdata), .i_imem_valid(valid),
    .o_imem_req(req), .o_imem_addr(addr), .o_ir(ir), .o_pc_out(pc_out)
  );

  if_stage #(.RESET_PC(16'hFFFF)) u_wrap (
    .i_clk(clk), .i_rst_n(w_rst_n), .i_stall(1'b0), .i_branch(1'b0),
    .i_pc_offset(16'h0000), .i_imem_rdata(w_rdata), .i_imem_valid(w_valid),
    .o_imem_req(w_req), .o_imem_addr(w_addr), .o_ir(w_ir), .o_pc_out(w_pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle memory for the wrap instance: data = 16'h1000 + address.
  always @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_valid <= 1'b0;
      w_rdata <= 16'h0000;
    end else begin
      w_valid <= w_req;
      w_rdata <= 16'h1000 + w_addr;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, cur, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic br, input logic [15:0] off,
                              input logic v, input logic [15:0] rd, input logic rq,
                              input logic [15:0] ad, input logic [15:0] i,
                              input logic [15:0] pc);
    vec_t t;
    t.stall = st; t.branch = br; t.offset = off; t.valid = v; t.rdata = rd;
    t.exp_req = rq; t.exp_addr = ad; t.exp_ir = i; t.exp_pc_out = pc;
    return t;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input vec_t v);
    stall = v.stall; branch = v.branch; offset = v.offset;
    valid = v.valid; rdata = v.rdata;
    #1;
    chk("imem_req", {15'd0, req}, {15'd0, v.exp_req});
    chk("imem_addr", addr, v.exp_addr);
    @(posedge clk);
    #1;
    chk("ir", ir, v.exp_ir);
    chk("pc_out", pc_out, v.exp_pc_out);
    @(negedge clk);
  endtask

  task automatic wstep(input logic rq, input logic [15:0] ad, input logic [15:0] i,
                       input logic [15:0] pc);
    #1;
    chk("wrap_req", {15'd0, w_req}, {15'd0, rq});
    chk("wrap_addr", w_addr, ad);
    @(posedge clk);
    #1;
    chk("wrap_ir", w_ir, i);
    chk("wrap_pc_out", w_pc_out, pc);
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; cur = -1;
    rst_n = 1'b0; w_rst_n = 1'b0;
    stall = 1'b0; branch = 1'b0; offset = 16'h0000; valid = 1'b0; rdata = 16'h0000;

    // reset and 1-cycle streaming
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 0,16'h0000,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0000,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1000, 1,16'h0001,16'h1000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1001, 1,16'h0002,16'h1001,16'h0001));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1002, 1,16'h0003,16'h1002,16'h0002));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1003, 1,16'h0004,16'h1003,16'h0003));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1004, 1,16'h0005,16'h1004,16'h0004));
    // 3-cycle stall with 16'h1005 returning into the skid buffer
    vecs.push_back(mk(1,0,16'h0000,1,16'h1005, 0,16'h0005,16'h1004,16'h0004));
    vecs.push_back(mk(1,0,16'h0000,0,16'h0000, 0,16'h0005,16'h1004,16'h0004));
    vecs.push_back(mk(1,0,16'h0000,0,16'h0000, 0,16'h0005,16'h1004,16'h0004));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 0,16'h0005,16'h1005,16'h0005));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0006,16'h0000,16'h0005));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1006, 1,16'h0007,16'h1006,16'h0006));
    // memory idle for 4 cycles
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 0,16'h0007,16'h0000,16'h0006));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1007, 1,16'h0008,16'h1007,16'h0007));
    // branch while waiting (target 7+1+8 = 16'h0010), drain the stale response
    vecs.push_back(mk(0,1,16'h0008,0,16'h0000, 0,16'h0008,16'h0000,16'h0007));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1008, 0,16'h0010,16'h0000,16'h0007));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0010,16'h0000,16'h0007));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1010, 1,16'h0011,16'h1010,16'h0010));
    // PC_OUT=16'h0010, offset 16'hFFFC -> target 16'h000D, 3-cycle memory drain
    vecs.push_back(mk(1,1,16'hFFFC,0,16'h0000, 0,16'h0011,16'h0000,16'h0010));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 0,16'h000D,16'h0000,16'h0010));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1011, 0,16'h000D,16'h0000,16'h0010));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h000D,16'h0000,16'h0010));
    vecs.push_back(mk(0,0,16'h0000,1,16'h100D, 1,16'h000E,16'h100D,16'h000D));
    // branch out of the skid buffer: target D+1+5 = 16'h0013
    vecs.push_back(mk(1,0,16'h0000,1,16'h100E, 0,16'h000E,16'h100D,16'h000D));
    vecs.push_back(mk(1,1,16'h0005,0,16'h0000, 0,16'h000E,16'h0000,16'h000D));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0013,16'h0000,16'h000D));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1013, 1,16'h0014,16'h1013,16'h0013));
    // two branches while draining, the later one (16'h0034) wins
    vecs.push_back(mk(0,1,16'h0010,0,16'h0000, 0,16'h0014,16'h0000,16'h0013));
    vecs.push_back(mk(0,1,16'h0020,0,16'h0000, 0,16'h0024,16'h0000,16'h0013));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1014, 0,16'h0034,16'h0000,16'h0013));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0034,16'h0000,16'h0013));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1034, 1,16'h0035,16'h1034,16'h0034));
    // VALID and BRANCH together: target 34+1-2 = 16'h0033
    vecs.push_back(mk(0,1,16'hFFFE,1,16'h1035, 0,16'h0035,16'h0000,16'h0034));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0033,16'h0000,16'h0034));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1033, 1,16'h0034,16'h1033,16'h0033));
    // hold, release, then branch in S_REQ (request still issued, then drained)
    vecs.push_back(mk(1,0,16'h0000,1,16'h1034, 0,16'h0034,16'h1033,16'h0033));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 0,16'h0034,16'h1034,16'h0034));
    vecs.push_back(mk(0,1,16'h0001,0,16'h0000, 1,16'h0035,16'h0000,16'h0034));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1035, 0,16'h0036,16'h0000,16'h0034));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0036,16'h0000,16'h0034));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1036, 1,16'h0037,16'h1036,16'h0036));
    // jump to 16'hFFFE (36+1+FFC7), then branch from FFFE with +3 -> 16'h0002
    vecs.push_back(mk(0,1,16'hFFC7,0,16'h0000, 0,16'h0037,16'h0000,16'h0036));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1037, 0,16'hFFFE,16'h0000,16'h0036));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'hFFFE,16'h0000,16'h0036));
    vecs.push_back(mk(0,0,16'h0000,1,16'h0FFE, 1,16'hFFFF,16'h0FFE,16'hFFFE));
    vecs.push_back(mk(0,1,16'h0003,1,16'h0FFF, 0,16'hFFFF,16'h0000,16'hFFFE));
    vecs.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0002,16'h0000,16'hFFFE));
    vecs.push_back(mk(0,0,16'h0000,1,16'h1002, 1,16'h0003,16'h1002,16'h0002));

    // reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {15'd0, req}, 16'h0000);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("wrap_rst_req", {15'd0, w_req}, 16'h0000);
    chk("wrap_rst_addr", w_addr, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cur = i;
      step(vecs[i]);
    end

    // asynchronous reset while a request is outstanding in S_WAIT
    cur = 1000;
    stall = 1'b0; branch = 1'b0; offset = 16'h0000; valid = 1'b0; rdata = 16'h0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {15'd0, req}, 16'h0000);
    chk("arst_addr", addr, 16'h0000);
    chk("arst_ir", ir, 16'h0000);
    chk("arst_pc_out", pc_out, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur = 1100 + i;
      step(vecs[i]);
    end

    // RESET_PC=16'hFFFF instance: addresses FFFF then 0000
    w_rst_n = 1'b1;
    cur = 2000; wstep(1'b0, 16'hFFFF, 16'h0000, 16'h0000);
    cur = 2001; wstep(1'b1, 16'hFFFF, 16'h0000, 16'h0000);
    cur = 2002; wstep(1'b1, 16'h0000, 16'h0FFF, 16'hFFFF);
    cur = 2003; wstep(1'b1, 16'h0001, 16'h1000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_if_stage

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipeline: the producer side of the decode stage's instruction interface. It owns the PC, fetches from a single-outstanding-request instruction memory, and drives the IF/ID register (IR, PC_OUT) into decode. It consumes decode's STALL, BRANCH and PC_OFFSET, inserts NOP bubbles, squashes on redirect, and buffers a returned instruction while decode is stalled.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- NOP, 16'h0000, bubble instruction (BR with nzp=000, never taken)

Ports (clock and reset first):
- CLK  in  1  single clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- STALL  in  1  decode stall; hold IR/PC_OUT
- BRANCH  in  1  taken branch resolved in decode
- PC_OFFSET  in  16  sign-extended branch offset from decode
- IMEM_RDATA  in  16  instruction data
- IMEM_VALID  in  1  IMEM_RDATA valid, one per request
- IMEM_REQ  out  1  single-cycle fetch request
- IMEM_ADDR  out  16  word address, valid while IMEM_REQ=1
- IR  out  16  IF/ID instruction register
- PC_OUT  out  16  PC of the instruction in IR

## Operation
- Word-addressed PC; sequential next PC = PC+1, mod 2^16.
- Branch target = PC_OUT + 1 + PC_OFFSET, 16-bit wrap, no overflow flag. PC_OUT still holds the branch's PC because decode stalls on BRANCH.
- Priority each cycle: BRANCH > STALL > deliver instruction > bubble.
- BRANCH: IR<=NOP, PC<=target, and any buffered or in-flight instruction is discarded.
- STALL (no BRANCH): IR and PC_OUT hold.
- Deliver: IR<=instruction, PC_OUT<=fetch PC, PC<=PC+1.
- Otherwise (no instruction, not stalled): IR<=NOP and PC_OUT holds.
- FSM states:
  - S_REQ: IMEM_REQ=1, IMEM_ADDR=PC; go to S_WAIT. BRANCH here updates PC, and the request already issued goes to S_DRAIN.
  - S_WAIT: on IMEM_VALID with BRANCH, discard and go to S_REQ at target. On IMEM_VALID with STALL, BUF<=RDATA and go to S_HOLD. On IMEM_VALID otherwise, deliver, issue the next request in the same cycle (IMEM_REQ=1, IMEM_ADDR=PC+1) and stay in S_WAIT. With no VALID and BRANCH, PC<=target and go to S_DRAIN.
  - S_DRAIN: a request is outstanding for a squashed address. On IMEM_VALID, discard and go to S_REQ. A further BRANCH only updates PC (latest wins).
  - S_HOLD: on BRANCH, drop BUF and go to S_REQ at target. On !STALL, deliver BUF and go to S_REQ.
- At most one request is outstanding. IMEM_REQ is never asserted in S_DRAIN or S_HOLD.

## Timing
- Reset values: IR=NOP, PC_OUT=16'h0000, PC=RESET_PC, IMEM_REQ=0, IMEM_ADDR=RESET_PC, state=S_REQ, BUF=NOP.
- First IMEM_REQ is in the first CLK edge cycle after RST_N deasserts.
- Memory latency is 1 or more cycles after the request cycle. With 1-cycle memory and no stalls, throughput is one instruction per cycle.
- IR updates on the edge where IMEM_VALID is sampled, so latency is request-to-IR = memory latency.
- IMEM_REQ and IMEM_ADDR are combinational from state, PC and IMEM_VALID/STALL/BRANCH. No combinational path from IMEM_RDATA to IMEM_REQ.
- Redirect penalty with 1-cycle memory and nothing in flight: BRANCH at edge n, request at target in cycle n+1, IR valid at n+2.
- Reset mid-fetch: the state machine returns to S_REQ. The memory is reset on the same RST_N, so no stale VALID is expected.
- PC wrap: 16'hFFFF+1 = 16'h0000. The branch target wraps identically.

## Structure
- Shared package pipeline_pkg holds:
  - state enum (S_REQ, S_WAIT, S_DRAIN, S_HOLD)
  - NOP constant
  - opcode constants (BR=4'b0000, ADD=4'b0001, LDW=4'b0110, STW=4'b0111)
  - WORD_W=16
- Single module, with no sub-module. The target adder and skid buffer (BUF) stay inline.

## Test plan
- Reset, 1-cycle memory returning 16'h1000+addr: IMEM_ADDR 0,1,2 on consecutive cycles; IR=16'h1000,16'h1001,16'h1002 with PC_OUT 0,1,2.
- STALL held 3 cycles while VALID returns 16'h1005: FSM enters S_HOLD; IR/PC_OUT hold; 16'h1005 appears the cycle after STALL drops, with no duplicate request.
- PC_OUT=16'h0010, BRANCH with PC_OFFSET=16'hFFFC: IR=NOP; next IMEM_ADDR=16'h000D; the in-flight response is discarded via S_DRAIN under 3-cycle memory.
- RESET_PC=16'hFFFF, no stalls: addresses FFFF then 0000. Branch from PC_OUT=16'hFFFE with offset 16'h0003: target 16'h0002.
- Memory idle 4 cycles, no STALL: IR=NOP each cycle and PC_OUT holds.
- RST_N pulsed low while in S_WAIT: all outputs return to reset values asynchronously; fetch restarts at RESET_PC.
